// File: rtl/wb_port_arbiter_pkg.sv
// Shared encodings for the register-file write-port arbiter: destination
// selects, arbitration states and the B-side queue geometry.
package wb_port_arbiter_pkg;

  localparam logic [1:0] SEL_RD = 2'b00;
  localparam logic [1:0] SEL_RT = 2'b01;
  localparam logic [1:0] SEL_RA = 2'b10;

  localparam logic [4:0] REG_RA = 5'd31;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned ENTRY_W    = 37;

  typedef enum logic {
    A_PRIO  = 1'b0,
    B_FORCE = 1'b1
  } arb_state_e;

  // Both 2'b10 and 2'b11 select the link register.
  function automatic logic [4:0] resolve_addr(input logic [1:0] sel,
                                              input logic [4:0] rd,
                                              input logic [4:0] rt);
    logic [4:0] addr;
    case (sel)
      SEL_RD:  addr = rd;
      SEL_RT:  addr = rt;
      default: addr = REG_RA;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO holding {addr, data} write-back results from the mul/div unit.
module wb_fifo2
  import wb_port_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;
  logic               push_ok, pop_ok;

  assign full    = (count_q == 2'(FIFO_DEPTH));
  assign empty   = (count_q == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; count_q gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the main datapath (A)
// and queued mul/div results (B), with bounded starvation of B.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [1:0]  a_sel,
  input  logic [4:0]  a_rd,
  input  logic [4:0]  a_rt,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  arb_state_e         state_q, state_d;
  logic [CW-1:0]      starve_q, starve_d;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               grant_a, grant_b;
  logic [4:0]         a_addr;
  logic [4:0]         b_head_addr;
  logic [31:0]        b_head_data;

  assign b_ready     = !fifo_full;
  assign a_ready     = (state_q == A_PRIO);
  assign grant_a     = a_ready && a_valid;
  assign grant_b     = !fifo_empty && !grant_a;
  assign a_addr      = resolve_addr(a_sel, a_rd, a_rt);
  assign b_head_addr = fifo_dout[36:32];
  assign b_head_data = fifo_dout[31:0];

  wb_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (b_valid && b_ready),
    .pop   (grant_b),
    .din   ({b_addr, b_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (state_q == B_FORCE) begin
      state_d  = A_PRIO;
      starve_d = '0;
    end else if (fifo_empty || grant_b) begin
      starve_d = '0;
    end else if (grant_a) begin
      starve_d = starve_q + CW'(1);
      // Force B on the cycle the bypass count hits its limit.
      if (starve_d == CW'(STARVE_MAX)) state_d = B_FORCE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= A_PRIO;
      starve_q <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rf_we    <= 1'b0;
      // Writes to r0 are consumed but never enabled.
      if (grant_a) begin
        rf_we    <= (a_addr != 5'd0);
        rf_waddr <= a_addr;
        rf_wdata <= a_data;
      end else if (grant_b) begin
        rf_we    <= (b_head_addr != 5'd0);
        rf_waddr <= b_head_addr;
        rf_wdata <= b_head_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [1:0]  a_sel;
  logic [4:0]  a_rd, a_rt;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int vectors     = 0;
  int miscompares = 0;

  wb_port_arbiter #(.STARVE_MAX(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_sel    (a_sel),
    .a_rd     (a_rd),
    .a_rt     (a_rt),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] addr,
                        input logic [31:0] data);
    chk({tag, ".we"},    32'(rf_we),    32'(we));
    chk({tag, ".waddr"}, 32'(rf_waddr), 32'(addr));
    chk({tag, ".wdata"}, rf_wdata,      data);
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; a_sel = 2'b00; a_rd = 5'd0; a_rt = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;

    // Reset state
    step(); step();
    chk_wr("reset", 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    chk("reset.a_ready", 32'(a_ready), 32'd1);
    chk("reset.b_ready", 32'(b_ready), 32'd1);

    // A only, each select encoding
    a_valid = 1'b1; a_sel = 2'b10; a_rd = 5'd7; a_rt = 5'd9; a_data = 32'hDEADBEEF;
    chk("a_only.a_ready", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    chk_wr("a_only", 1'b1, 5'd31, 32'hDEADBEEF);
    step();
    chk_wr("idle_hold", 1'b0, 5'd31, 32'hDEADBEEF);
    a_valid = 1'b1; a_sel = 2'b01; a_data = 32'h0000_0055;
    step();
    chk_wr("sel_rt", 1'b1, 5'd9, 32'h0000_0055);
    a_sel = 2'b00; a_data = 32'h0000_0066;
    step();
    chk_wr("sel_rd", 1'b1, 5'd7, 32'h0000_0066);
    a_sel = 2'b11; a_data = 32'h0000_0077;
    step();
    chk_wr("sel_11", 1'b1, 5'd31, 32'h0000_0077);
    a_valid = 1'b0;

    // B only
    b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h0000_1234;
    step();
    b_valid = 1'b0;
    chk("b_only.b_ready", 32'(b_ready), 32'd1);
    step();
    chk_wr("b_only", 1'b1, 5'd5, 32'h0000_1234);
    chk("b_only.b_ready2", 32'(b_ready), 32'd1);
    step();
    chk("b_only.drained", 32'(rf_we), 32'd0);

    // Starvation: one queued entry bypassed three times, then forced
    a_valid = 1'b1; a_sel = 2'b00; a_rd = 5'd10; a_data = 32'h0000_00A0;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h0000_0066;
    step();
    b_valid = 1'b0;
    chk_wr("starve.a0", 1'b1, 5'd10, 32'h0000_00A0);
    a_data = 32'd1;
    step();
    chk_wr("starve.a1", 1'b1, 5'd10, 32'd1);
    chk("starve.rdy1", 32'(a_ready), 32'd1);
    a_data = 32'd2;
    step();
    chk_wr("starve.a2", 1'b1, 5'd10, 32'd2);
    chk("starve.rdy2", 32'(a_ready), 32'd1);
    a_data = 32'd3;
    step();
    chk_wr("starve.a3", 1'b1, 5'd10, 32'd3);
    chk("starve.force_rdy", 32'(a_ready), 32'd0);
    a_data = 32'd4;
    step();
    chk_wr("starve.b", 1'b1, 5'd6, 32'h0000_0066);
    chk("starve.resume_rdy", 32'(a_ready), 32'd1);
    a_data = 32'd5;
    step();
    chk_wr("starve.resume", 1'b1, 5'd10, 32'd5);
    a_valid = 1'b0;
    step();

    // Full: three pushes while A holds the port
    a_valid = 1'b1; a_sel = 2'b01; a_rt = 5'd2; a_data = 32'h0000_0AAA;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h0000_00B1;
    chk("full.rdy0", 32'(b_ready), 32'd1);
    step();
    chk("full.rdy1", 32'(b_ready), 32'd1);
    b_addr = 5'd12; b_data = 32'h0000_00B2;
    step();
    chk("full.rdy2", 32'(b_ready), 32'd0);
    b_addr = 5'd13; b_data = 32'h0000_00B3;
    step();
    chk("full.rdy3", 32'(b_ready), 32'd0);
    chk_wr("full.a", 1'b1, 5'd2, 32'h0000_0AAA);
    b_valid = 1'b0; a_valid = 1'b0;
    step();
    chk_wr("full.drain1", 1'b1, 5'd11, 32'h0000_00B1);
    chk("full.rdy4", 32'(b_ready), 32'd1);
    step();
    chk_wr("full.drain2", 1'b1, 5'd12, 32'h0000_00B2);
    step();
    chk_wr("full.empty", 1'b0, 5'd12, 32'h0000_00B2);

    // Zero address on both sides
    a_valid = 1'b1; a_sel = 2'b00; a_rd = 5'd0; a_data = 32'h0000_00FF;
    chk("zero.a_ready", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    chk("zero.a_we", 32'(rf_we), 32'd0);
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_0077;
    step();
    b_valid = 1'b0;
    step();
    chk("zero.b_we", 32'(rf_we), 32'd0);
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h0000_0033;
    step();
    b_valid = 1'b0;
    chk("zero.after_pop_we", 32'(rf_we), 32'd0);
    step();
    chk_wr("zero.next_b", 1'b1, 5'd3, 32'h0000_0033);

    // Reset with two queued entries
    a_valid = 1'b1; a_sel = 2'b10; a_data = 32'h0000_00AA;
    b_valid = 1'b1; b_addr = 5'd20; b_data = 32'h0000_00C1;
    step();
    b_addr = 5'd21; b_data = 32'h0000_00C2;
    step();
    b_valid = 1'b0; a_valid = 1'b0;
    chk("rst.full", 32'(b_ready), 32'd0);
    chk_wr("rst.pre", 1'b1, 5'd31, 32'h0000_00AA);
    #2 rst = 1'b1;
    #1;
    chk_wr("rst.async", 1'b0, 5'd0, 32'd0);
    step();
    chk_wr("rst.hold", 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    chk("rst.b_ready", 32'(b_ready), 32'd1);
    chk("rst.a_ready", 32'(a_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_wr("rst.no_stale", 1'b0, 5'd0, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: the maximum number of consecutive cycles a queued B entry may be bypassed by A.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port a_valid, input, 1 bit: the main datapath requests a register-file write this cycle.
REQ-005 Port a_sel, input, 2 bits: A destination select; 00 = a_rd, 01 = a_rt, 10 or 11 = register 31.
REQ-006 Port a_rd, input, 5 bits: rd field of the A instruction.
REQ-007 Port a_rt, input, 5 bits: rt field of the A instruction.
REQ-008 Port a_data, input, 32 bits: A write data.
REQ-009 Port a_ready, output, 1 bit: A is accepted this cycle.
REQ-010 Port b_valid, input, 1 bit: the mul/div unit offers a write-back result.
REQ-011 Port b_addr, input, 5 bits: B destination register.
REQ-012 Port b_data, input, 32 bits: B write data.
REQ-013 Port b_ready, output, 1 bit: the B queue can accept an entry.
REQ-014 Port rf_we, output, 1 bit: registered register-file write enable.
REQ-015 Port rf_waddr, output, 5 bits: registered write address.
REQ-016 Port rf_wdata, output, 32 bits: registered write data.

Function
REQ-017 B results SHALL enter a 2-entry FIFO on (b_valid && b_ready); b_ready = (count < 2), derived from registered count only.
REQ-018 A full FIFO with a simultaneous pop SHALL still deassert b_ready (no same-cycle push-through).
REQ-019 Arbitration state SHALL be the 2-state machine A_PRIO / B_FORCE plus a starve counter of width clog2(STARVE_MAX+1).
REQ-020 In A_PRIO: a_valid grants A; otherwise a non-empty FIFO grants its head entry.
REQ-021 The starve counter SHALL increment on each cycle A is granted while the FIFO is non-empty, and SHALL clear when the FIFO is empty or B is granted.
REQ-022 When the starve counter reaches STARVE_MAX, the next state SHALL be B_FORCE.
REQ-023 In B_FORCE: the FIFO head SHALL be granted, a_ready = 0, and the next state SHALL be A_PRIO with the counter cleared.
REQ-024 In A_PRIO, a_ready SHALL be 1.
REQ-025 An A grant SHALL drive rf_waddr by a_sel per REQ-005 and rf_wdata = a_data.
REQ-026 A B grant SHALL pop the FIFO head and drive its address and data.
REQ-027 Latency SHALL be one cycle: rf_we/rf_waddr/rf_wdata are registered on the grant edge.
REQ-028 With no grant, rf_we SHALL be 0; rf_waddr and rf_wdata SHALL hold their last values.
REQ-029 Any granted write whose resolved address is 0 SHALL be consumed (FIFO popped or A accepted) with rf_we = 0.
REQ-030 Register-file writes SHALL occur in grant order; same-address conflicts are resolved solely by that order, and no merging is performed.
REQ-031 FIFO pointers SHALL be 1 bit and wrap modulo 2.

Reset
REQ-032 rst SHALL immediately set rf_we = 0, rf_waddr = 0, rf_wdata = 0, state = A_PRIO, starve counter = 0, FIFO count = 0 and both FIFO pointers = 0.
REQ-033 After reset, a_ready = 1 and b_ready = 1.
REQ-034 Queued B entries SHALL be discarded on reset mid-operation, and no write SHALL be issued in the reset cycle.

Structure
REQ-035 A shared package SHALL hold the a_sel encodings, the constant REG_RA = 31, the state encodings (A_PRIO, B_FORCE) and the FIFO depth 2.
REQ-036 The FIFO SHALL be one sub-module, wb_fifo2 (push/pop/full/empty, 37-bit entries).

Verification
REQ-037 A only: a_valid=1, a_sel=10, a_data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=31, rf_wdata=0xDEADBEEF.
REQ-038 B only: push {addr 5, data 0x1234} -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; b_ready stays 1.
REQ-039 Starvation: FIFO holds 1 entry, a_valid held 1 -> A is granted 3 cycles, then a_ready=0 for 1 cycle and the B entry is written, then A resumes.
REQ-040 Full: 3 consecutive B pushes while A is held -> b_ready=0 after 2, third push refused; entries drain in order.
REQ-041 Zero address: a_sel=00, a_rd=0 -> a_ready=1, next cycle rf_we=0; a B entry with b_addr=0 is popped with rf_we=0.
REQ-042 Reset: assert rst with 2 queued entries -> outputs cleared asynchronously, b_ready=1 after release, no stale write ever appears.
